// File: rtl/msb_align.sv
// Multi-cycle bit-placement unit: shifts an operand one bit per cycle until its
// most-significant set bit sits on a requested index, plus one-hot/mask decode of that index.
module msb_align #(
  parameter int WIDTH = 32,
  parameter int IDXW  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] operand,
  input  logic [IDXW-1:0]  target,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [IDXW:0]    shift_count,
  output logic             shift_left,
  output logic             zero_op,
  output logic [WIDTH-1:0] onehot,
  output logic [WIDTH-1:0] mask
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] work_reg, work_next;
  logic [IDXW-1:0]  tgt_reg, tgt_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic [IDXW:0]    count_reg, count_next;
  logic             left_reg, left_next;
  logic             zero_reg, zero_next;
  logic [WIDTH-1:0] onehot_reg, onehot_next;
  logic [WIDTH-1:0] mask_reg, mask_next;

  logic [WIDTH-1:0] onehot_dec, mask_dec;
  logic [IDXW-1:0]  msb_idx;

  // Index decode straight from the target input so it can be captured with start.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_dec
      assign onehot_dec[gi] = (target == IDXW'(gi));
      assign mask_dec[gi]   = (IDXW'(gi) <= target);
    end
  endgenerate

  // Priority encode of the working value; highest set bit wins.
  always_comb begin
    msb_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (work_reg[i]) msb_idx = IDXW'(i);
    end
  end

  always_comb begin
    state_next  = state_reg;
    work_next   = work_reg;
    tgt_next    = tgt_reg;
    result_next = result_reg;
    count_next  = count_reg;
    left_next   = left_reg;
    zero_next   = zero_reg;
    onehot_next = onehot_reg;
    mask_next   = mask_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          state_next  = SHIFT;
          work_next   = operand;
          tgt_next    = target;
          onehot_next = onehot_dec;
          mask_next   = mask_dec;
          count_next  = '0;
          left_next   = 1'b0;
          zero_next   = 1'b0;
        end else begin
          state_next = IDLE;
        end
      end
      SHIFT: begin
        if (work_reg == '0) begin
          zero_next   = 1'b1;
          result_next = '0;
          state_next  = DONE;
        end else if (msb_idx == tgt_reg) begin
          result_next = work_reg;
          state_next  = DONE;
        end else if (msb_idx < tgt_reg) begin
          work_next  = work_reg << 1;
          count_next = count_reg + 1'b1;
          left_next  = 1'b1;
        end else begin
          work_next  = work_reg >> 1;
          count_next = count_reg + 1'b1;
          left_next  = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      work_reg   <= '0;
      tgt_reg    <= '0;
      result_reg <= '0;
      count_reg  <= '0;
      left_reg   <= 1'b0;
      zero_reg   <= 1'b0;
      onehot_reg <= '0;
      mask_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      work_reg   <= work_next;
      tgt_reg    <= tgt_next;
      result_reg <= result_next;
      count_reg  <= count_next;
      left_reg   <= left_next;
      zero_reg   <= zero_next;
      onehot_reg <= onehot_next;
      mask_reg   <= mask_next;
    end
  end

  assign busy        = (state_reg == SHIFT);
  assign done        = (state_reg == DONE);
  assign result      = result_reg;
  assign shift_count = count_reg;
  assign shift_left  = left_reg;
  assign zero_op     = zero_reg;
  assign onehot      = onehot_reg;
  assign mask        = mask_reg;

endmodule
